// File: rtl/demux_pkg.sv
// Shared definitions for the round-robin demux dispatcher.
// Lane count, lane index type and the rotating-priority lane search.
package demux_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned LANE_IDX_W = 2;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  // First set bit of mask searching start, start+1, ... (mod NUM_LANES); start if none set.
  function automatic lane_idx_t next_free_lane(input logic [NUM_LANES-1:0] mask,
                                               input lane_idx_t            start);
    lane_idx_t pick;
    lane_idx_t cand;
    logic      found;
    pick  = start;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cand = start + lane_idx_t'(i);
      if (!found && mask[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/demux_rr_dispatcher_lane_slot.sv
// lane_slot: one-entry output register slice for a single dispatcher lane.
// A load in the same cycle as a drain wins, so the lane never bubbles.
module lane_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Next-state: load overrides drain; data holds its last value on drain.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: steers an input valid/ready stream to four one-entry
// lanes in rotating order; sel exports the lane pointer to the 1-to-4 demux.
// Build option: define DEMUX_SKIP_BUSY_EN for work-conserving lane selection
// (skip lanes that cannot load); otherwise strict round robin.
module demux_rr_dispatcher
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [LANE_IDX_W-1:0]      sel
);

  lane_idx_t            sel_q, sel_d;
  lane_idx_t            target_c;
  logic                 accept_c;
  logic [NUM_LANES-1:0] can_load_c;
  logic [NUM_LANES-1:0] load_c;
  logic [NUM_LANES-1:0] drain_c;

  assign can_load_c = ~out_valid | out_ready;

`ifdef DEMUX_SKIP_BUSY_EN
  // Work-conserving: first lane able to load, starting at the pointer.
  assign target_c = next_free_lane(can_load_c, sel_q);
  assign in_ready = |can_load_c;
  assign sel      = target_c;
`else
  // Strict round robin: only the pointed lane may take the word.
  assign target_c = sel_q;
  assign in_ready = can_load_c[sel_q];
  assign sel      = sel_q;
`endif

  assign accept_c = in_valid & in_ready;

  // Pointer advance: one past the lane that took the word.
  always_comb begin
    sel_d = sel_q;
    if (accept_c) begin
      sel_d = target_c + lane_idx_t'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign load_c[k]  = accept_c & (target_c == lane_idx_t'(k));
    assign drain_c[k] = out_valid[k] & out_ready[k];

    lane_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_c[k]),
      .drain_i (drain_c[k]),
      .data_i  (in_data),
      .data_o  (out_data[k*WIDTH +: WIDTH]),
      .valid_o (out_valid[k])
    );
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Testbench for demux_rr_dispatcher: directed scenarios plus randomized
// traffic, all compared against a lane/queue-level reference model.
module tb_demux_rr_dispatcher;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  sel;

  int errors = 0;
  int checks = 0;

  // Reference model: lane contents, lane-full flags and pointer.
  logic [7:0] md [4];
  logic [3:0] mv;
  int         msel;

  demux_rr_dispatcher #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_data();
    return {md[3], md[2], md[1], md[0]};
  endfunction

  function automatic logic model_can(input int k, input logic [3:0] r);
    return !mv[k] || r[k];
  endfunction

  // Lane the model would pick for the given out_ready, or -1 if none.
  function automatic int model_target(input logic [3:0] r);
`ifdef DEMUX_SKIP_BUSY_EN
    for (int i = 0; i < 4; i++) begin
      if (model_can((msel + i) % 4, r)) return (msel + i) % 4;
    end
    return -1;
`else
    return model_can(msel, r) ? msel : -1;
`endif
  endfunction

  task automatic model_reset();
    mv   = 4'b0000;
    msel = 0;
    for (int k = 0; k < 4; k++) md[k] = 8'h00;
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [3:0] r);
    int t;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    t = model_target(r);
    check("in_ready", 32'(in_ready), 32'(t >= 0));
    check("sel_pre", 32'(sel), 32'((t >= 0) ? t : msel));
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (mv[k] && r[k]) mv[k] = 1'b0;
    if (v && t >= 0) begin
      md[t] = d;
      mv[t] = 1'b1;
      msel  = (t + 1) % 4;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(mv));
    check("out_data", out_data, model_data());
    check("sel_post", 32'(sel), 32'(msel));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 4'b0000;
    model_reset();
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_data", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(in_ready), 32'h1);
  endtask

  initial begin
    logic [7:0] seq [5];
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Streaming with all consumers ready.
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) cyc(1'b1, seq[i], 4'b1111);
    check("stream_l0", 32'(out_data[7:0]), 32'h55);
    check("stream_sel", 32'(sel), 32'h1);
    cyc(1'b0, 8'h00, 4'b1111);

    // Back-pressure: fill all lanes, then stall, then free lane 0.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, seq[i], 4'b0000);
    check("stall_valid", 32'(out_valid), 32'hF);
    check("stall_data", out_data, 32'h44332211);
    cyc(1'b1, 8'h55, 4'b0001);
    check("unstall_l0", 32'(out_data[7:0]), 32'h55);
    check("unstall_v0", 32'(out_valid[0]), 32'h1);

    // Busy lane 1 at the pointer with lane 2 free.
    do_reset();
    cyc(1'b1, 8'hC1, 4'b0000);
    cyc(1'b1, 8'hC2, 4'b0000);
    cyc(1'b1, 8'hC3, 4'b0000);
    cyc(1'b1, 8'hC4, 4'b0001);
    cyc(1'b1, 8'hC5, 4'b0100);
    check("busy_setup_v", 32'(out_valid), 32'hB);
    check("busy_setup_sel", 32'(sel), 32'h1);
    cyc(1'b1, 8'hC6, 4'b0000);
`ifdef DEMUX_SKIP_BUSY_EN
    check("skip_sel", 32'(sel), 32'h3);
    check("skip_l2", 32'(out_data[23:16]), 32'hC6);
`else
    check("strict_sel", 32'(sel), 32'h1);
    check("strict_v", 32'(out_valid), 32'hB);
`endif

    // Same-edge drain and load on lane 2.
    do_reset();
    cyc(1'b1, 8'h10, 4'b1111);
    cyc(1'b1, 8'h11, 4'b1111);
    cyc(1'b1, 8'hA0, 4'b1011);
    cyc(1'b1, 8'h13, 4'b1011);
    cyc(1'b1, 8'h14, 4'b1011);
    cyc(1'b1, 8'h15, 4'b1011);
    check("same_old", 32'(out_data[23:16]), 32'hA0);
    cyc(1'b1, 8'hB0, 4'b0100);
    check("same_new", 32'(out_data[23:16]), 32'hB0);
    check("same_v2", 32'(out_valid[2]), 32'h1);

    // Async reset mid-cycle with lanes 0 and 3 full, sel = 2.
    do_reset();
    cyc(1'b1, 8'h21, 4'b0000);
    cyc(1'b1, 8'h22, 4'b0000);
    cyc(1'b1, 8'h23, 4'b0010);
    cyc(1'b1, 8'h24, 4'b0100);
    cyc(1'b1, 8'h25, 4'b0001);
    cyc(1'b1, 8'h26, 4'b0000);
    cyc(1'b0, 8'h00, 4'b0010);
    check("pre_rst_v", 32'(out_valid), 32'h9);
    check("pre_rst_sel", 32'(sel), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("async_v", 32'(out_valid), 32'h0);
    check("async_sel", 32'(sel), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 8'h77, 4'b0000);
    check("post_rst_l0", 32'(out_data[7:0]), 32'h77);

    // Idle cycle between words.
    do_reset();
    cyc(1'b1, 8'h01, 4'b0000);
    cyc(1'b0, 8'hEE, 4'b0000);
    check("idle_sel", 32'(sel), 32'h1);
    cyc(1'b1, 8'h02, 4'b0000);
    check("idle_v", 32'(out_valid), 32'h3);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
